shift_add_multiplier: RTL
=========================

# shift_add_multiplier

Sequential unsigned multiplier that time-shares a single `ripple_carry_adder` over `width` cycles to form a `2*width`-bit product. It accepts one operand pair through a valid/ready handshake and runs one conditional add-and-shift step per cycle. It presents the held result through a second valid/ready handshake. It sits in the arithmetic datapath wherever area matters more than throughput.

## Interface
- `width`, default 4: operand width in bits; legal range ≥ 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: operand pair `a`/`b` is valid.
- `in_ready`  out  1: block can accept operands; high only in IDLE.
- `a`  in  `width`: multiplicand, unsigned.
- `b`  in  `width`: multiplier, unsigned.
- `out_valid`  out  1: `product` is valid; high only in DONE.
- `out_ready`  in  1: consumer accepts `product`.
- `product`  out  `2*width`: unsigned `a*b`, held stable while `out_valid` is high.

## Operation
- Internal registers:
  - `mcand`: `width` bits, multiplicand.
  - `acc_hi`: `width` bits, upper partial product.
  - `acc_lo`: `width` bits, initially the multiplier and shifted out LSB-first.
  - `cnt`: `$clog2(width+1)` bits, step counter.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, load `mcand`←`a`, `acc_hi`←0, `acc_lo`←`b`, `cnt`←0, then go to BUSY.
- BUSY, one step per cycle:
  - The adder computes `acc_hi + (acc_lo[0] ? mcand : 0)` with `cin` = 0.
  - `{acc_hi, acc_lo}` ← `{cout, sum, acc_lo[width-1:1]}`.
  - `cnt`←`cnt`+1.
  - When the step with `cnt == width-1` completes, go to DONE.
- DONE:
  - `out_valid` = 1.
  - `product` = `{acc_hi, acc_lo}`.
  - On `out_ready`, go to IDLE.
  - Registers are untouched until the next load.
- Adder operand B is gated to zero when `acc_lo[0]` = 0. No adder bypass is used; the same datapath serves every step.
- No overflow is possible: the adder carry-out is always captured as the shifted-in MSB.
- Inputs `in_valid`, `a` and `b` are ignored outside IDLE. The block never accepts a second operand pair while busy or holding a result.
- `out_ready` is ignored outside DONE.
- Reset, asserted at any time including mid-BUSY or in DONE:
  - State goes to IDLE immediately.
  - All registers clear to 0.
  - Any in-progress result is discarded with no partial output.
- Outputs during reset: `in_ready` = 0 while `rst_n` is low, and 1 after release. `out_valid` = 0. `product` = 0.

## Timing
- Operand accept occurs on the edge where `in_valid && in_ready` (edge k).
- BUSY occupies edges k+1 … k+width, exactly `width` cycles regardless of operand values.
- `out_valid` rises after edge k+width.
- Latency from accept edge to first `out_valid` cycle is `width` cycles.
- Result transfer occurs on the edge where `out_valid && out_ready`. `in_ready` is high in the following cycle.
- Minimum initiation interval is `width`+2 cycles (accept, `width` steps, drain).
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- The critical path is the `width`-bit ripple adder plus the operand mux.

## Structure
- Shared package/include holds:
  - the FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the counter-width function.
- One sub-module is used: a single `ripple_carry_adder #(.width(width))` instance. All other logic (FSM, counter, shift registers, operand gating) is local.
- Adder `sum`/`cout` feed the shift register directly; no additional pipeline registers.

## Test plan
- Reset, then `a`=13, `b`=11 with `out_ready`=1 held: `out_valid` appears exactly 4 cycles after the accept edge with `product`=143 (8'h8F), then `in_ready` returns.
- `a`=15, `b`=15: `product`=225 (8'hE1); checks the carry-out capture on every step.
- `a`=0, `b`=9, then `a`=7, `b`=0: `product`=0 both times, with identical 4-cycle latency.
- Back-pressure: `out_ready` held low 5 cycles after `out_valid`, with `in_valid` toggling:
  - `product` is stable;
  - `in_ready` is 0;
  - no new operand is accepted;
  - the transfer completes when `out_ready`=1.
- Assert `rst_n` low at step 2 of BUSY (`a`=9, `b`=6):
  - outputs go to 0 immediately and `out_valid` never rises;
  - after release, `a`=3, `b`=5 gives `product`=15.
- Random sweep: 1000 random pairs at `width`=4 and `width`=8, with random handshake stalls. Compare against the reference model `a*b`.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding and
// the step-counter width helper.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand and result valid/ready handshakes of the shift-and-add multiplier.
interface shift_add_multiplier_if #(
  parameter int width = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [width-1:0]     a;
  logic [width-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*width-1:0]   product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/ripple_carry_adder.sv
// Plain width-bit ripple-carry adder; the multiplier's only arithmetic unit.
module ripple_carry_adder #(
  parameter int width = 4
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] sum,
  output logic             cout
);

  logic [width:0] carry;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop can leave a value unassigned and infer a latch.
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < width; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[width];
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one conditional add-and-shift per cycle
// through a shared ripple adder, width steps per product.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_multiplier_if.slave bus
);

  localparam int              cw        = cnt_width(width);
  localparam logic [cw-1:0]   last_step = cw'(width - 1);

  state_t            state;
  logic [width-1:0]  mcand;
  logic [width-1:0]  acc_hi;
  logic [width-1:0]  acc_lo;
  logic [cw-1:0]     cnt;

  logic [width-1:0]  addend;
  logic [width-1:0]  sum;
  logic              cout;

  // The multiplier LSB selects whether this step adds the multiplicand.
  assign addend = acc_lo[0] ? mcand : '0;

  ripple_carry_adder #(.width(width)) u_adder (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are cleared as well, so product reads 0 in
      // reset and no earlier result can leak out afterwards.
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= bus.a;
            acc_hi <= '0;
            acc_lo <= bus.b;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          // Carry-out becomes the new MSB, so the product can never overflow.
          {acc_hi, acc_lo} <= {cout, sum, acc_lo[width-1:1]};
          cnt              <= cnt + cw'(1);
          if (cnt == last_step) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is held low while reset is asserted, not just decoded from IDLE.
  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = {acc_hi, acc_lo};

endmodule
